// File: rtl/sdram_wr_buf_if.sv
// Write-buffer port bundle: user push side plus the sdram_top burst pop side.
// The slave modport is the buffer; the master modport is the user/sdram_top pair driving it.
interface sdram_wr_buf_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 16
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              usr_wr_en;
    logic [DATA_W-1:0] usr_wr_data;
    logic              usr_full;
    logic [CNT_W-1:0]  usr_count;
    logic              wr_trig;
    logic              wr_busy;
    logic              wfifo_rd_en;
    logic [DATA_W-1:0] wfifo_rd_data;
    logic              ovf_err;
    logic              udf_err;

    modport master (
        output usr_wr_en,
        output usr_wr_data,
        output wfifo_rd_en,
        input  usr_full,
        input  usr_count,
        input  wr_trig,
        input  wr_busy,
        input  wfifo_rd_data,
        input  ovf_err,
        input  udf_err
    );

    modport slave (
        input  usr_wr_en,
        input  usr_wr_data,
        input  wfifo_rd_en,
        output usr_full,
        output usr_count,
        output wr_trig,
        output wr_busy,
        output wfifo_rd_data,
        output ovf_err,
        output udf_err
    );
endinterface

// File: rtl/sdram_wr_buf.sv
// Write-side staging FIFO for sdram_top: buffers user words, requests a burst once
// BURST_LEN words are held, and serves the burst pops with first-word-fall-through data.
module sdram_wr_buf #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic           sclk,
    input  logic           s_rst_n,
    sdram_wr_buf_if.slave  bus
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRIG  = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_nxt;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_nxt;
    logic [BEAT_W-1:0]   beat_q;

    logic                full_q;
    logic                trig_q;
    logic                busy_q;
    logic                ovf_q;
    logic                udf_q;

    logic                is_full;
    logic                is_empty;
    logic                push_ok;
    logic                pop_ok;
    logic                last_beat;

    // Accept conditions are decided on the current count, so a pop never frees
    // room for a push in the same cycle.
    assign is_full   = (count_q == CNT_W'(DEPTH));
    assign is_empty  = (count_q == '0);
    assign push_ok   = bus.usr_wr_en && !is_full;
    assign pop_ok    = bus.wfifo_rd_en && !is_empty && (state_q == BURST);
    assign last_beat = (beat_q == BEAT_W'(BURST_LEN - 1));

    // State register
    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (count_q >= CNT_W'(BURST_LEN)) begin
                    state_nxt = TRIG;
                end
            end
            TRIG: begin
                state_nxt = BURST;
            end
            BURST: begin
                if (pop_ok && last_beat) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Occupancy update
    always_comb begin
        count_nxt = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count_q + CNT_W'(1);
            2'b01:   count_nxt = count_q - CNT_W'(1);
            default: count_nxt = count_q;
        endcase
    end

    // Storage is left uncleared by reset; only the pointers define what is live.
    always_ff @(posedge sclk) begin
        if (s_rst_n && push_ok) begin
            mem[wr_ptr_q] <= bus.usr_wr_data;
        end
    end

    // Pointers, count, beat counter and registered status outputs
    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            beat_q   <= '0;
            full_q   <= 1'b0;
            trig_q   <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_nxt;

            if (state_q == TRIG) begin
                beat_q <= '0;
            end else if (pop_ok) begin
                beat_q <= beat_q + BEAT_W'(1);
            end

            // Registered copies track the state/count they will reflect next cycle.
            full_q <= (count_nxt == CNT_W'(DEPTH));
            trig_q <= (state_nxt == TRIG);
            busy_q <= (state_nxt != IDLE);

            if (bus.usr_wr_en && is_full) begin
                ovf_q <= 1'b1;
            end
            if (bus.wfifo_rd_en && !pop_ok) begin
                udf_q <= 1'b1;
            end
        end
    end

    assign bus.usr_full      = full_q;
    assign bus.usr_count     = count_q;
    assign bus.wr_trig       = trig_q;
    assign bus.wr_busy       = busy_q;
    assign bus.ovf_err       = ovf_q;
    assign bus.udf_err       = udf_q;
    assign bus.wfifo_rd_data = is_empty ? '0 : mem[rd_ptr_q];

endmodule

// File: tb/tb_sdram_wr_buf.sv
// Directed bench for sdram_wr_buf: trigger timing, burst drain, full/overflow,
// pointer wrap with concurrent traffic, underflow and mid-burst reset.
module tb_sdram_wr_buf;
    logic sclk    = 1'b0;
    logic s_rst_n = 1'b0;

    int n_cmp    = 0;
    int n_err    = 0;
    int trig_cnt = 0;
    logic [15:0] push_val = 16'h0000;

    always #5 sclk = ~sclk;

    sdram_wr_buf_if #(.DATA_W(16), .DEPTH(16)) bus ();

    sdram_wr_buf #(.DATA_W(16), .DEPTH(16), .BURST_LEN(4)) dut (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .bus     (bus)
    );

    // Count trigger pulses mid-cycle
    always @(negedge sclk) begin
        if (bus.wr_trig === 1'b1) trig_cnt++;
    end

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic reset_dut();
        s_rst_n          = 1'b0;
        bus.usr_wr_en    = 1'b0;
        bus.usr_wr_data  = 16'h0000;
        bus.wfifo_rd_en  = 1'b0;
        tick();
        tick();
        s_rst_n = 1'b1;
    endtask

    task automatic push_seq(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            bus.usr_wr_en   = 1'b1;
            bus.usr_wr_data = base + 16'(i);
            tick();
        end
        bus.usr_wr_en = 1'b0;
    endtask

    // Advance until the buffer sits in its burst phase (busy, trigger already gone)
    task automatic wait_burst(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.wr_busy === 1'b1 && bus.wr_trig === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic drain_burst(input logic [15:0] exp_base, input bit push_too, input string tag);
        bit ok;
        wait_burst(ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s burst_wait: wr_busy=%b wr_trig=%b, required busy=1 trig=0 within 8 cycles",
                     tag, bus.wr_busy, bus.wr_trig);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (bus.wfifo_rd_data !== exp_base + 16'(i)) begin
                n_err++;
                $display("FAIL %s pop%0d_data: got %h required %h", tag, i, bus.wfifo_rd_data, exp_base + 16'(i));
            end
            bus.wfifo_rd_en = 1'b1;
            if (push_too) begin
                bus.usr_wr_en   = 1'b1;
                bus.usr_wr_data = push_val;
                push_val        = push_val + 16'd1;
            end
            tick();
        end
        bus.wfifo_rd_en = 1'b0;
        bus.usr_wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        n_cmp++; if (bus.wr_trig !== 1'b0)        begin n_err++; $display("FAIL reset_trig: got %b required 0", bus.wr_trig); end
        n_cmp++; if (bus.wr_busy !== 1'b0)        begin n_err++; $display("FAIL reset_busy: got %b required 0", bus.wr_busy); end
        n_cmp++; if (bus.usr_full !== 1'b0)       begin n_err++; $display("FAIL reset_full: got %b required 0", bus.usr_full); end
        n_cmp++; if (bus.usr_count !== 5'd0)      begin n_err++; $display("FAIL reset_count: got %0d required 0", bus.usr_count); end
        n_cmp++; if (bus.ovf_err !== 1'b0)        begin n_err++; $display("FAIL reset_ovf: got %b required 0", bus.ovf_err); end
        n_cmp++; if (bus.udf_err !== 1'b0)        begin n_err++; $display("FAIL reset_udf: got %b required 0", bus.udf_err); end
        n_cmp++; if (bus.wfifo_rd_data !== 16'h0) begin n_err++; $display("FAIL reset_rd_data: got %h required 0000", bus.wfifo_rd_data); end
    endtask

    task automatic test_trig_timing();
        int t0;
        reset_dut();
        t0 = trig_cnt;
        push_seq(16'h1000, 4);
        n_cmp++; if (bus.usr_count !== 5'd4) begin n_err++; $display("FAIL trig_count: got %0d required 4", bus.usr_count); end
        n_cmp++; if (bus.wr_trig !== 1'b0)   begin n_err++; $display("FAIL trig_early: got %b required 0", bus.wr_trig); end
        tick();
        n_cmp++; if (bus.wr_trig !== 1'b1)   begin n_err++; $display("FAIL trig_pulse: got %b required 1", bus.wr_trig); end
        n_cmp++; if (bus.wr_busy !== 1'b1)   begin n_err++; $display("FAIL trig_busy: got %b required 1", bus.wr_busy); end
        tick();
        n_cmp++; if (bus.wr_trig !== 1'b0)   begin n_err++; $display("FAIL trig_single: got %b required 0", bus.wr_trig); end
        n_cmp++; if (bus.wr_busy !== 1'b1)   begin n_err++; $display("FAIL trig_burst_busy: got %b required 1", bus.wr_busy); end
        n_cmp++; if (bus.wfifo_rd_data !== 16'h1000) begin n_err++; $display("FAIL trig_head: got %h required 1000", bus.wfifo_rd_data); end
        n_cmp++; if (trig_cnt - t0 !== 1)    begin n_err++; $display("FAIL trig_pulses: got %0d required 1", trig_cnt - t0); end
    endtask

    task automatic test_drain();
        int t0;
        reset_dut();
        t0 = trig_cnt;
        push_seq(16'h1000, 4);
        drain_burst(16'h1000, 1'b0, "drain");
        n_cmp++; if (bus.wr_busy !== 1'b0)        begin n_err++; $display("FAIL drain_busy_fall: got %b required 0", bus.wr_busy); end
        n_cmp++; if (bus.usr_count !== 5'd0)      begin n_err++; $display("FAIL drain_count: got %0d required 0", bus.usr_count); end
        n_cmp++; if (bus.wfifo_rd_data !== 16'h0) begin n_err++; $display("FAIL drain_empty_data: got %h required 0000", bus.wfifo_rd_data); end
        n_cmp++; if (bus.udf_err !== 1'b0)        begin n_err++; $display("FAIL drain_udf: got %b required 0", bus.udf_err); end
        for (int i = 0; i < 4; i++) tick();
        n_cmp++; if (trig_cnt - t0 !== 1)         begin n_err++; $display("FAIL drain_trigs: got %0d required 1", trig_cnt - t0); end
    endtask

    task automatic test_full_overflow();
        int t0;
        reset_dut();
        t0 = trig_cnt;
        push_seq(16'h2000, 16);
        n_cmp++; if (bus.usr_full !== 1'b1)   begin n_err++; $display("FAIL full_flag: got %b required 1", bus.usr_full); end
        n_cmp++; if (bus.usr_count !== 5'd16) begin n_err++; $display("FAIL full_count: got %0d required 16", bus.usr_count); end
        n_cmp++; if (bus.ovf_err !== 1'b0)    begin n_err++; $display("FAIL full_ovf_early: got %b required 0", bus.ovf_err); end
        push_seq(16'h2FFF, 1);
        n_cmp++; if (bus.ovf_err !== 1'b1)    begin n_err++; $display("FAIL ovf_set: got %b required 1", bus.ovf_err); end
        n_cmp++; if (bus.usr_count !== 5'd16) begin n_err++; $display("FAIL ovf_count: got %0d required 16", bus.usr_count); end
        for (int i = 0; i < 3; i++) tick();
        n_cmp++; if (trig_cnt - t0 !== 1)     begin n_err++; $display("FAIL full_one_trig: got %0d required 1", trig_cnt - t0); end
        for (int b = 0; b < 4; b++) drain_burst(16'h2000 + 16'(4 * b), 1'b0, "full");
        n_cmp++; if (bus.usr_count !== 5'd0)  begin n_err++; $display("FAIL full_drained_count: got %0d required 0", bus.usr_count); end
        n_cmp++; if (bus.usr_full !== 1'b0)   begin n_err++; $display("FAIL full_cleared: got %b required 0", bus.usr_full); end
        n_cmp++; if (bus.ovf_err !== 1'b1)    begin n_err++; $display("FAIL ovf_sticky: got %b required 1", bus.ovf_err); end
        n_cmp++; if (trig_cnt - t0 !== 4)     begin n_err++; $display("FAIL full_trigs: got %0d required 4", trig_cnt - t0); end
    endtask

    task automatic test_wrap_concurrent();
        int t0;
        reset_dut();
        t0 = trig_cnt;
        push_seq(16'h3000, 8);
        push_val = 16'h3008;
        for (int b = 0; b < 4; b++) begin
            drain_burst(16'h3000 + 16'(4 * b), 1'b1, "wrap");
            n_cmp++;
            if (bus.usr_count !== 5'd8) begin
                n_err++;
                $display("FAIL wrap_count_b%0d: got %0d required 8", b, bus.usr_count);
            end
        end
        drain_burst(16'h3010, 1'b0, "wrap_tail");
        drain_burst(16'h3014, 1'b0, "wrap_tail");
        n_cmp++; if (bus.usr_count !== 5'd0) begin n_err++; $display("FAIL wrap_final_count: got %0d required 0", bus.usr_count); end
        n_cmp++; if (trig_cnt - t0 !== 6)    begin n_err++; $display("FAIL wrap_trigs: got %0d required 6", trig_cnt - t0); end
        n_cmp++; if (bus.udf_err !== 1'b0)   begin n_err++; $display("FAIL wrap_udf: got %b required 0", bus.udf_err); end
    endtask

    task automatic test_underflow_idle();
        reset_dut();
        push_seq(16'h4000, 2);
        tick();
        tick();
        n_cmp++; if (bus.udf_err !== 1'b0)   begin n_err++; $display("FAIL udf_early: got %b required 0", bus.udf_err); end
        n_cmp++; if (bus.wr_busy !== 1'b0)   begin n_err++; $display("FAIL udf_idle: got %b required 0", bus.wr_busy); end
        bus.wfifo_rd_en = 1'b1;
        tick();
        bus.wfifo_rd_en = 1'b0;
        n_cmp++; if (bus.udf_err !== 1'b1)   begin n_err++; $display("FAIL udf_set: got %b required 1", bus.udf_err); end
        n_cmp++; if (bus.usr_count !== 5'd2) begin n_err++; $display("FAIL udf_count: got %0d required 2", bus.usr_count); end
        n_cmp++; if (bus.wfifo_rd_data !== 16'h4000) begin n_err++; $display("FAIL udf_rd_ptr: got %h required 4000", bus.wfifo_rd_data); end
        tick();
        n_cmp++; if (bus.udf_err !== 1'b1)   begin n_err++; $display("FAIL udf_sticky: got %b required 1", bus.udf_err); end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        int t1;
        reset_dut();
        push_seq(16'h5000, 4);
        wait_burst(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL midrst_wait: busy=%b trig=%b required busy=1 trig=0", bus.wr_busy, bus.wr_trig); end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (bus.wfifo_rd_data !== 16'h5000 + 16'(i)) begin
                n_err++;
                $display("FAIL midrst_pop%0d: got %h required %h", i, bus.wfifo_rd_data, 16'h5000 + 16'(i));
            end
            bus.wfifo_rd_en = 1'b1;
            tick();
        end
        bus.wfifo_rd_en = 1'b0;
        s_rst_n = 1'b0;
        tick();
        n_cmp++; if (bus.wr_busy !== 1'b0)        begin n_err++; $display("FAIL midrst_busy: got %b required 0", bus.wr_busy); end
        n_cmp++; if (bus.wr_trig !== 1'b0)        begin n_err++; $display("FAIL midrst_trig: got %b required 0", bus.wr_trig); end
        n_cmp++; if (bus.usr_count !== 5'd0)      begin n_err++; $display("FAIL midrst_count: got %0d required 0", bus.usr_count); end
        n_cmp++; if (bus.wfifo_rd_data !== 16'h0) begin n_err++; $display("FAIL midrst_rd_data: got %h required 0000", bus.wfifo_rd_data); end
        n_cmp++; if (bus.usr_full !== 1'b0)       begin n_err++; $display("FAIL midrst_full: got %b required 0", bus.usr_full); end
        s_rst_n = 1'b1;
        t1 = trig_cnt;
        push_seq(16'h6000, 4);
        drain_burst(16'h6000, 1'b0, "post_rst");
        n_cmp++; if (trig_cnt - t1 !== 1)    begin n_err++; $display("FAIL postrst_trigs: got %0d required 1", trig_cnt - t1); end
        n_cmp++; if (bus.usr_count !== 5'd0) begin n_err++; $display("FAIL postrst_count: got %0d required 0", bus.usr_count); end
        n_cmp++; if (bus.wr_busy !== 1'b0)   begin n_err++; $display("FAIL postrst_busy: got %b required 0", bus.wr_busy); end
    endtask

    initial begin
        bus.usr_wr_en   = 1'b0;
        bus.usr_wr_data = 16'h0000;
        bus.wfifo_rd_en = 1'b0;
        test_reset();
        test_trig_timing();
        test_drain();
        test_full_overflow();
        test_wrap_concurrent();
        test_underflow_idle();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end
endmodule
